// File: rtl/sim_clk_gen_if.sv
// rtl/sim_clk_gen_if.sv - signal bundle between a clock/strobe generator and its consumer
// Purpose : groups the enable input and the generated clock/strobe/counter outputs.
// Ports   : en        - count enable (consumer -> generator)
//           clk_out   - generated square wave
//           rise/fall - one-cycle edge strobes of clk_out
//           phase_cnt - generator counter value, W bits
// Modports: master = generator side, slave = consumer side.
interface sim_clk_gen_if #(
  parameter int W = 1
);
  logic         en;
  logic         clk_out;
  logic         rise;
  logic         fall;
  logic [W-1:0] phase_cnt;

  modport master (input en, output clk_out, output rise, output fall, output phase_cnt);
  modport slave  (output en, input clk_out, input rise, input fall, input phase_cnt);
endinterface

// File: rtl/sim_clk_gen.sv
// rtl/sim_clk_gen.sv - periodic clock/strobe generator with T-cycle period
// Purpose : derives a registered square wave of period T system clocks, low for
//           T/2 cycles and high for the rest, plus single-cycle rise/fall strobes.
// Params  : T     - output period in clk cycles (>= 2)
//           PHASE - counter value loaded by reset (0..T-1)
// Ports   : clk   - system clock, rising-edge active
//           rst_n - asynchronous active-low reset
//           bus   - sim_clk_gen_if.master (en in; clk_out, rise, fall, phase_cnt out)
module sim_clk_gen #(
  parameter int T     = 2,
  parameter int PHASE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  sim_clk_gen_if.master  bus
);

  localparam int W = (T > 2) ? $clog2(T) : 1;
  localparam int L = T / 2;

  localparam logic [W-1:0] C_LAST    = W'(T - 1);
  localparam logic [W-1:0] C_L       = W'(L);
  localparam logic [W-1:0] C_PHASE   = W'(PHASE);
  localparam logic         C_CO_RST  = (PHASE >= L);

  if (T < 2) begin : g_bad_t
    $error("sim_clk_gen: T must be at least 2");
  end
  if (PHASE < 0 || PHASE >= T) begin : g_bad_phase
    $error("sim_clk_gen: PHASE must lie in 0..T-1");
  end

  logic [W-1:0] r_cnt;
  logic         r_clk_out;
  logic         r_rise;
  logic         r_fall;
  logic [W-1:0] w_cnt_next;

  // Explicit compare against T-1 so non-power-of-two periods never reach T.
  always_comb begin
    w_cnt_next = (r_cnt == C_LAST) ? '0 : (r_cnt + W'(1));
  end

  // Every output is decoded from the next count, so all of them are registers
  // and change together on the same edge as phase_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= C_PHASE;
      r_clk_out <= C_CO_RST;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else if (bus.en) begin
      r_cnt     <= w_cnt_next;
      r_clk_out <= (w_cnt_next >= C_L);
      r_rise    <= (w_cnt_next == C_L);
      r_fall    <= (w_cnt_next == '0);
    end else begin
      // Frozen: count and level hold, strobes drop so nothing downstream
      // sees a repeated edge while stalled.
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end
  end

  assign bus.phase_cnt = r_cnt;
  assign bus.clk_out   = r_clk_out;
  assign bus.rise      = r_rise;
  assign bus.fall      = r_fall;

endmodule

// File: tb/tb_sim_clk_gen.sv
// tb/tb_sim_clk_gen.sv - scoreboard testbench for sim_clk_gen
module tb_sim_clk_gen;

  localparam int NI = 5;
  // instance table: 0=T2, 1=T8, 2=T5, 3=T8 gated, 4=T8 PHASE3 (own reset)
  int t_tab [NI] = '{2, 8, 5, 8, 8};
  int p_tab [NI] = '{0, 0, 0, 0, 3};

  logic clk;
  logic rst_n;
  logic rst_b;

  sim_clk_gen_if #(.W(1)) if_t2  ();
  sim_clk_gen_if #(.W(3)) if_t8  ();
  sim_clk_gen_if #(.W(3)) if_t5  ();
  sim_clk_gen_if #(.W(3)) if_t8g ();
  sim_clk_gen_if #(.W(3)) if_t8p ();

  sim_clk_gen #(.T(2), .PHASE(0)) u_t2  (.clk(clk), .rst_n(rst_n), .bus(if_t2));
  sim_clk_gen #(.T(8), .PHASE(0)) u_t8  (.clk(clk), .rst_n(rst_n), .bus(if_t8));
  sim_clk_gen #(.T(5), .PHASE(0)) u_t5  (.clk(clk), .rst_n(rst_n), .bus(if_t5));
  sim_clk_gen #(.T(8), .PHASE(0)) u_t8g (.clk(clk), .rst_n(rst_n), .bus(if_t8g));
  sim_clk_gen #(.T(8), .PHASE(3)) u_t8p (.clk(clk), .rst_n(rst_b), .bus(if_t8p));

  typedef struct {
    int id;
    int cnt;
    bit co;
    bit ri;
    bit fa;
  } exp_t;

  exp_t sb_q [$];
  int   m_cnt [NI];
  bit   m_co  [NI];
  bit   m_en  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_en(input int i, input bit v);
    m_en[i] = v;
    case (i)
      0:       if_t2.en  = v;
      1:       if_t8.en  = v;
      2:       if_t5.en  = v;
      3:       if_t8g.en = v;
      default: if_t8p.en = v;
    endcase
  endtask

  task automatic model_reset(input int i);
    m_cnt[i] = p_tab[i];
    m_co[i]  = (p_tab[i] >= t_tab[i] / 2);
  endtask

  function automatic exp_t get_act(input int i);
    exp_t a;
    a.id = i;
    case (i)
      0: begin a.cnt = int'(if_t2.phase_cnt);  a.co = if_t2.clk_out;  a.ri = if_t2.rise;  a.fa = if_t2.fall;  end
      1: begin a.cnt = int'(if_t8.phase_cnt);  a.co = if_t8.clk_out;  a.ri = if_t8.rise;  a.fa = if_t8.fall;  end
      2: begin a.cnt = int'(if_t5.phase_cnt);  a.co = if_t5.clk_out;  a.ri = if_t5.rise;  a.fa = if_t5.fall;  end
      3: begin a.cnt = int'(if_t8g.phase_cnt); a.co = if_t8g.clk_out; a.ri = if_t8g.rise; a.fa = if_t8g.fall; end
      default: begin a.cnt = int'(if_t8p.phase_cnt); a.co = if_t8p.clk_out; a.ri = if_t8p.rise; a.fa = if_t8p.fall; end
    endcase
    return a;
  endfunction

  // Push the expected post-edge state of every instance, take one clock edge,
  // then pop and compare against what the instances show 1ns later.
  task automatic step();
    exp_t e;
    exp_t a;
    for (int i = 0; i < NI; i++) begin
      e.id = i;
      if (m_en[i]) begin
        m_cnt[i] = (m_cnt[i] == t_tab[i] - 1) ? 0 : m_cnt[i] + 1;
        m_co[i]  = (m_cnt[i] >= t_tab[i] / 2);
        e.ri     = (m_cnt[i] == t_tab[i] / 2);
        e.fa     = (m_cnt[i] == 0);
      end else begin
        e.ri = 1'b0;
        e.fa = 1'b0;
      end
      e.cnt = m_cnt[i];
      e.co  = m_co[i];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      e = sb_q.pop_front();
      a = get_act(e.id);
      check($sformatf("i%0d_cnt", e.id),  a.cnt,     e.cnt);
      check($sformatf("i%0d_clko", e.id), int'(a.co), int'(e.co));
      check($sformatf("i%0d_rise", e.id), int'(a.ri), int'(e.ri));
      check($sformatf("i%0d_fall", e.id), int'(a.fa), int'(e.fa));
    end
  endtask

  initial begin
    logic [31:0] t2_mask;
    logic [31:0] t8_rmask;
    logic [31:0] t8_fmask;
    int          t5_max;
    int          seq [5];
    int          r2;
    int          r8;
    exp_t        a;

    t2_mask  = '0;
    t8_rmask = '0;
    t8_fmask = '0;
    t5_max   = 0;
    seq      = '{4, 5, 6, 7, 0};

    rst_n = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < NI; i++) begin
      set_en(i, 1'b1);
      model_reset(i);
    end
    #12;

    // reset state straight from the spec
    for (int i = 0; i < NI; i++) begin
      a = get_act(i);
      check($sformatf("rst_i%0d_cnt", i),  a.cnt,      p_tab[i]);
      check($sformatf("rst_i%0d_clko", i), int'(a.co), int'(p_tab[i] >= t_tab[i] / 2));
      check($sformatf("rst_i%0d_rise", i), int'(a.ri), 0);
      check($sformatf("rst_i%0d_fall", i), int'(a.fa), 0);
    end

    rst_n = 1'b1;
    rst_b = 1'b1;

    // free run, 24 edges
    for (int e = 1; e <= 24; e++) begin
      step();
      if (e <= 8) t2_mask[e] = if_t2.clk_out;
      if (if_t8.rise) t8_rmask[e] = 1'b1;
      if (if_t8.fall) t8_fmask[e] = 1'b1;
      if (int'(if_t5.phase_cnt) > t5_max) t5_max = int'(if_t5.phase_cnt);
    end
    check("t2_clko_edges1_8", int'(t2_mask), 32'h0000_00AA);
    check("t8_rise_edges",    int'(t8_rmask), 32'h0010_1010);
    check("t8_fall_edges",    int'(t8_fmask), 32'h0101_0100);
    check("t5_max_cnt",       t5_max, 4);

    // enable gating on the T=8 gated instance at cnt=5
    for (int k = 0; k < 5; k++) step();
    check("gate_pre_cnt", int'(if_t8g.phase_cnt), 5);
    set_en(3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("gate_hold_cnt",  int'(if_t8g.phase_cnt), 5);
      check("gate_hold_clko", int'(if_t8g.clk_out), 1);
      check("gate_hold_strb", int'(if_t8g.rise | if_t8g.fall), 0);
    end
    set_en(3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("gate_resume_cnt", int'(if_t8g.phase_cnt), 6 + k - ((k == 2) ? 8 : 0));
      check("gate_resume_fall", int'(if_t8g.fall), (k == 2) ? 1 : 0);
    end

    // async reset mid-period on the PHASE=3 instance, asserted at cnt=6
    for (int k = 0; k < 8 && m_cnt[4] != 6; k++) step();
    check("arst_pre_cnt", int'(if_t8p.phase_cnt), 6);
    #3;
    rst_b = 1'b0;
    #1;
    check("arst_cnt",  int'(if_t8p.phase_cnt), 3);
    check("arst_clko", int'(if_t8p.clk_out), 0);
    check("arst_strb", int'(if_t8p.rise | if_t8p.fall), 0);
    model_reset(4);
    #2;
    rst_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("arst_seq_cnt", int'(if_t8p.phase_cnt), seq[k]);
      if (k == 0) check("arst_first_clko", int'(if_t8p.clk_out), 1);
      if (k == 4) check("arst_last_fall",  int'(if_t8p.fall), 1);
    end

    // rate ratio of two instances sharing clk/rst_n
    r2 = 0;
    r8 = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (if_t2.rise) r2++;
      if (if_t8.rise) r8++;
    end
    check("ratio_t2_rises", r2, 32);
    check("ratio_t8_rises", r8, 8);

    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_clk_gen.md
Name: sim_clk_gen

Overview:
- Synthesizable periodic clock/strobe generator.
- Derives a square-wave `clk_out` of period T cycles of the system clock, plus single-cycle rise and fall strobes.
- Used to build multi-rate test and sim environments: a fast domain with the default T, a slow domain with e.g. T=8.
- Feeds producer/consumer logic such as FIFO pointer controllers.

Parameters:
- T, default 2: output period in `clk` cycles; legal range T >= 2.
- PHASE, default 0: counter reset value, range 0..T-1; skews the output's starting phase.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; when low the generator freezes.
- clk_out  output  1  generated square wave (registered).
- rise  output  1  one-cycle strobe, high in the cycle clk_out became 1.
- fall  output  1  one-cycle strobe, high in the cycle clk_out became 0.
- phase_cnt  output  $clog2(T)  current counter value, 0..T-1, for debug and alignment.

Behaviour:
- Constants:
  - L = T/2 (integer division) is the low-phase length.
  - H = T - L is the high-phase length; H >= L, so odd T gives the extra cycle to the high phase.
- Reset (rst_n=0, asynchronous, takes effect immediately regardless of clk):
  - phase_cnt = PHASE.
  - clk_out = (PHASE >= L).
  - rise = 0, fall = 0.
- Counter, on each rising clk edge with en=1:
  - cnt_next = 0 if cnt == T-1, else cnt+1.
  - All outputs are registered from cnt_next in that same edge:
    - clk_out <= (cnt_next >= L).
    - rise <= (cnt_next == L).
    - fall <= (cnt_next == 0).
  - Exception for T=2 with L=1: rise and fall alternate every cycle. This is consistent with the rules above.
- Enable low, on each rising clk edge with en=0:
  - phase_cnt and clk_out hold.
  - rise and fall are forced to 0.
  - Re-asserting en resumes from the held count with no skipped or duplicated phases.
- Resulting waveform from reset with PHASE=0 and en held high:
  - clk_out stays 0 for L edges, then 1 for H edges, repeating.
  - Exact period is T cycles; no drift.
- rise and fall are never high in the same cycle. Each occurs exactly once per T enabled cycles.
- Reset mid-operation:
  - Outputs return to their reset values immediately.
  - The first edge after rst_n deasserts behaves as edge 1 from PHASE.
- Wrap-around: phase_cnt must never hold a value >= T. For non-power-of-two T the counter explicitly compares against T-1 rather than relying on width overflow.
- Release of rst_n coincident with a clk edge: design treats the edge as occurring while still in reset. The integration must synchronise rst_n deassertion.
- Elaboration:
  - Illegal parameters (T < 2, PHASE >= T) must stop elaboration with an error.
  - Counter width is max($clog2(T),1).
- No combinational path from any input to any output other than the asynchronous reset.

Test Plan:
- Default T=2, PHASE=0, en=1 after reset:
  - clk_out = 1,0,1,0… on edges 1,2,3,4.
  - rise high after odd edges, fall high after even edges.
  - phase_cnt alternates 1,0.
- T=8, PHASE=0, en=1 for 24 edges:
  - clk_out low for edges 1–3 (cnt 1–3).
  - clk_out high for edges 4–7, low for edge 8 (cnt 0).
  - Period measured as exactly 8.
  - rise at edges 4, 12, 20; fall at edges 8, 16, 24.
- T=5 (odd), PHASE=0:
  - L=2, H=3.
  - clk_out high when cnt is 2,3,4 and low when cnt is 0,1.
  - phase_cnt never reaches 5.
- Enable gating, T=8:
  - Drop en for 3 cycles at cnt=5: cnt holds 5, clk_out holds 1, rise and fall stay 0.
  - Re-enable: next values are 6,7,0, with fall on the 0.
- Async reset mid-period, T=8, PHASE=3:
  - Assert rst_n=0 between clk edges while cnt=6.
  - phase_cnt becomes 3 and clk_out 0 without a clk edge.
  - After release, sequence resumes 4(clk_out=1), 5, 6, 7, 0(fall).
- Two instances with T=2 and T=8 driven from the same clk/rst_n:
  - rise count ratio over 64 cycles is exactly 32:8.
  - The instances never interfere with each other.
